id_hazard_scoreboard: RTL and testbench
=======================================

# id_hazard_scoreboard

Pipeline hazard controller for the decode stage. It tracks the destination registers of in-flight instructions in the EXE and MEM stages and compares them against the sources of the instruction currently in decode. On a read-after-write conflict it freezes PC and IF/ID and inserts a bubble into ID/EXE. It also applies branch flushes and keeps saturating stall and flush statistics.

## Interface
Parameters:
- FORWARD_EN, default 0: 1 means a forwarding unit exists, so only load-use hazards stall.
- CNT_W, default 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- freeze  in  1  global pipeline hold (memory wait). While 1, all internal state holds.
- id_valid  in  1  decode holds a real instruction (0 after a flush or bubble).
- id_src1  in  4  Rn index (instruction[19:16]).
- id_src2  in  4  second source index, already muxed (Rm or Rd).
- id_src1_used  in  1  Rn is read by this instruction.
- id_src2_used  in  1  second source is read by this instruction.
- id_wb_en  in  1  decode instruction writes back (post-condition-check control).
- id_mem_read  in  1  decode instruction is a load.
- id_dest  in  4  destination index (instruction[15:12]).
- branch_taken  in  1  branch resolved taken in EXE this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  write NOP controls into ID/EXE.
- flush  out  1  clear IF/ID.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- Tracker entries are exe_{v,dest,ld} and mem_{v,dest}.
- On each clk edge with rst=1 and freeze=0:
  - exe_v is set to issue, where issue = id_valid & id_wb_en & ~stall & ~branch_taken.
  - exe_dest is set to id_dest; exe_ld is set to id_mem_read & issue.
  - mem_v is set to exe_v; mem_dest is set to exe_dest.
- WB-stage writes are not tracked. The register file writes before decode reads in the same cycle.
- Match conditions:
  - m_exe = exe_v & ((id_src1_used & id_src1==exe_dest) | (id_src2_used & id_src2==exe_dest)).
  - m_mem is the same expression using mem_v and mem_dest.
- Hazard:
  - FORWARD_EN=0: hazard = m_exe | m_mem.
  - FORWARD_EN=1: hazard = m_exe & exe_ld.
- Outputs, all combinational:
  - stall = id_valid & hazard & ~branch_taken.
  - bubble = stall | branch_taken.
  - flush = branch_taken.
- Priority: branch_taken overrides hazard. The decode instruction is squashed, so no stall occurs and it is not issued.
- Counter updates, only when freeze=0:
  - stall_cycles increments when stall=1.
  - flush_count increments when branch_taken=1.
  - Both saturate at all-ones and do not wrap.
- While freeze=1:
  - Tracker and counters hold.
  - stall, bubble and flush still reflect inputs combinationally; the pipeline registers ignore them because they are frozen.
- Register index 15 (PC) is compared like any other register; there is no special case.

## Timing
- stall, bubble and flush have zero-cycle latency: combinational from inputs and tracker state in the same cycle.
- Tracker and counters have one-cycle latency: registered.
- Reset (rst=0 at a clk edge):
  - exe_v, mem_v, exe_ld become 0; exe_dest and mem_dest become 0.
  - stall_cycles and flush_count become 0.
  - Consequently stall=0 and bubble=flush=branch_taken.
- Reset mid-stall: the tracker is cleared at that edge, so stall drops in the next cycle regardless of decode contents.
- Expected stall lengths for a producer followed immediately by a consumer:
  - FORWARD_EN=0: 2 cycles, first matching exe, then mem.
  - FORWARD_EN=1 with a load producer: 1 cycle.
  - FORWARD_EN=1 with a non-load producer: 0 cycles.
- Simultaneous branch_taken and hazard: flush=1, bubble=1, stall=0. No entry is issued into exe.
- While stall=1, a bubble enters exe (exe_v=0) each cycle. The older entry advances to mem, then retires.

## Structure
- Shared package ("arm_pkg") holds:
  - REG_IDX_W=4 and the PC_IDX=15 constant.
  - The in-flight entry typedef {v, dest, ld}.
- One natural sub-module, "sat_counter" (parameter W; ports clk, rst, en, q). It is instantiated twice, for stall_cycles and flush_count.
- The tracker and match logic stay inline.

## Test plan
- FORWARD_EN=0. Issue an ADD writing R1, then decode a SUB reading R1 as src1. Required: stall=1 for exactly 2 cycles, bubble=1 on both, then issue; stall_cycles=2.
- FORWARD_EN=1. Issue an LDR writing R3, then decode an ADD reading R3 as src2. Required: stall=1 for 1 cycle. An ADD producer instead requires stall=0.
- Hazard on R2 coincident with branch_taken=1. Required: stall=0, flush=1, bubble=1, exe_v=0 next cycle, flush_count increments by 1.
- Consumer reads R4 with id_src1_used=0, and exe holds R4. Required: stall=0. Repeat with id_wb_en=0 on the producer: no later stall.
- Hazard on R5 with freeze=1 held for 3 cycles. Required: stall stays 1, tracker unchanged, stall_cycles unchanged. After release, stall clears with normal FORWARD_EN=0 timing.
- CNT_W=3 with 10 forced stall cycles. Required: stall_cycles=7 and holds at 7. Then rst=0 for one edge: counters=0, stall=0.

Source files
------------

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared decode-hazard types and constants.
// Register index width, PC index, in-flight entry.
package arm_pkg;

  localparam int REG_IDX_W = 4;
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] dest;
    logic                 ld;
  } entry_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Decode-side hazard bundle between ID and scoreboard.
// master drives decode info, slave returns controls/stats.
interface id_hazard_scoreboard_if
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                 freeze;
  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_src1;
  logic [REG_IDX_W-1:0] id_src2;
  logic                 id_src1_used;
  logic                 id_src2_used;
  logic                 id_wb_en;
  logic                 id_mem_read;
  logic [REG_IDX_W-1:0] id_dest;
  logic                 branch_taken;
  logic                 stall;
  logic                 bubble;
  logic                 flush;
  logic [CNT_W-1:0]     stall_cycles;
  logic [CNT_W-1:0]     flush_count;

  modport master (
    output freeze, id_valid,
    output id_src1, id_src2,
    output id_src1_used, id_src2_used,
    output id_wb_en, id_mem_read,
    output id_dest, branch_taken,
    input  stall, bubble, flush,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  freeze, id_valid,
    input  id_src1, id_src2,
    input  id_src1_used, id_src2_used,
    input  id_wb_en, id_mem_read,
    input  id_dest, branch_taken,
    output stall, bubble, flush,
    output stall_cycles, flush_count
  );

endinterface

// File: rtl/id_hazard_scoreboard_sat_counter.sv
// Saturating up-counter with sync active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // advance unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// RAW hazard scoreboard for decode: tracks EXE/MEM
// destinations, stalls/bubbles on conflict, flushes on branch.
module id_hazard_scoreboard
  import arm_pkg::*;
#(
  parameter int FORWARD_EN = 0,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  id_hazard_scoreboard_if.slave hz
);

  entry_t               exe_q, exe_d;
  logic                 mem_v_q, mem_v_d;
  logic [REG_IDX_W-1:0] mem_dest_q, mem_dest_d;

  logic m_exe, m_mem, hazard;
  logic stall_w, issue;

  // source match against in-flight destinations
  always_comb begin
    m_exe = exe_q.v &
      ((hz.id_src1_used & (hz.id_src1 == exe_q.dest)) |
       (hz.id_src2_used & (hz.id_src2 == exe_q.dest)));
    m_mem = mem_v_q &
      ((hz.id_src1_used & (hz.id_src1 == mem_dest_q)) |
       (hz.id_src2_used & (hz.id_src2 == mem_dest_q)));
    if (FORWARD_EN != 0) hazard = m_exe & exe_q.ld;
    else                 hazard = m_exe | m_mem;
    stall_w = hz.id_valid & hazard & ~hz.branch_taken;
    issue   = hz.id_valid & hz.id_wb_en &
              ~stall_w & ~hz.branch_taken;
  end

  assign hz.stall  = stall_w;
  assign hz.bubble = stall_w | hz.branch_taken;
  assign hz.flush  = hz.branch_taken;

  // tracker next state; freeze holds everything
  always_comb begin
    exe_d      = exe_q;
    mem_v_d    = mem_v_q;
    mem_dest_d = mem_dest_q;
    if (!hz.freeze) begin
      exe_d.v    = issue;
      exe_d.dest = hz.id_dest;
      exe_d.ld   = hz.id_mem_read & issue;
      mem_v_d    = exe_q.v;
      mem_dest_d = exe_q.dest;
    end
  end

  // tracker registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_q      <= '0;
      mem_v_q    <= 1'b0;
      mem_dest_q <= '0;
    end else begin
      exe_q      <= exe_d;
      mem_v_q    <= mem_v_d;
      mem_dest_q <= mem_dest_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_w & ~hz.freeze),
    .q   (hz.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hz.branch_taken & ~hz.freeze),
    .q   (hz.flush_count)
  );

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: three instances
// (no-fwd, fwd, 3-bit counters) share one stimulus stream.
module tb_id_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       fz, v, u1, u2, wb, ld, br;
  logic [3:0] s1, s2, dst;

  int total = 0;
  int passed = 0;

  id_hazard_scoreboard_if #(.CNT_W(16)) if0 ();
  id_hazard_scoreboard_if #(.CNT_W(16)) if1 ();
  id_hazard_scoreboard_if #(.CNT_W(3))  if2 ();

  assign if0.freeze = fz; assign if1.freeze = fz; assign if2.freeze = fz;
  assign if0.id_valid = v; assign if1.id_valid = v; assign if2.id_valid = v;
  assign if0.id_src1 = s1; assign if1.id_src1 = s1; assign if2.id_src1 = s1;
  assign if0.id_src2 = s2; assign if1.id_src2 = s2; assign if2.id_src2 = s2;
  assign if0.id_src1_used = u1; assign if1.id_src1_used = u1;
  assign if2.id_src1_used = u1;
  assign if0.id_src2_used = u2; assign if1.id_src2_used = u2;
  assign if2.id_src2_used = u2;
  assign if0.id_wb_en = wb; assign if1.id_wb_en = wb; assign if2.id_wb_en = wb;
  assign if0.id_mem_read = ld; assign if1.id_mem_read = ld;
  assign if2.id_mem_read = ld;
  assign if0.id_dest = dst; assign if1.id_dest = dst; assign if2.id_dest = dst;
  assign if0.branch_taken = br; assign if1.branch_taken = br;
  assign if2.branch_taken = br;

  id_hazard_scoreboard #(.FORWARD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .hz(if0.slave));
  id_hazard_scoreboard #(.FORWARD_EN(1), .CNT_W(16)) u1_dut (
    .clk(clk), .rst(rst), .hz(if1.slave));
  id_hazard_scoreboard #(.FORWARD_EN(0), .CNT_W(3)) u2_dut (
    .clk(clk), .rst(rst), .hz(if2.slave));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle();
    fz = 0; v = 0; u1 = 0; u2 = 0; wb = 0; ld = 0; br = 0;
    s1 = 0; s2 = 0; dst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic prod(input logic [3:0] d, input logic isld,
                      input logic w);
    idle();
    v = 1; wb = w; ld = isld; dst = d;
    #1;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_stall", if0.stall, 0);
    chk("rst_bubble", if0.bubble, 0);
    chk("rst_sc", if0.stall_cycles, 0);
    chk("rst_fc", if0.flush_count, 0);
    br = 1; #1;
    chk("rst_flush_br", if0.flush, 1);
    chk("rst_bubble_br", if0.bubble, 1);
    br = 0;

    // ADD R1 then SUB reading R1 (no forwarding)
    prod(4'd1, 0, 1);
    chk("s1_prod_stall", if0.stall, 0);
    tick();
    idle(); v = 1; wb = 1; dst = 4'd2; s1 = 4'd1; u1 = 1; #1;
    chk("s1_stall_exe", if0.stall, 1);
    chk("s1_bubble_exe", if0.bubble, 1);
    tick();
    chk("s1_stall_mem", if0.stall, 1);
    chk("s1_bubble_mem", if0.bubble, 1);
    chk("s1_exe_v_bubble", u0.exe_q.v, 0);
    tick();
    chk("s1_stall_clear", if0.stall, 0);
    chk("s1_sc", if0.stall_cycles, 2);
    tick();
    chk("s1_issued", u0.exe_q.v, 1);
    chk("s1_issued_dest", u0.exe_q.dest, 2);

    // LDR R3 then ADD reading R3 as src2 (forwarding)
    do_reset();
    prod(4'd3, 1, 1);
    tick();
    idle(); v = 1; wb = 1; dst = 4'd4; s2 = 4'd3; u2 = 1; #1;
    chk("s2_ld_stall", if1.stall, 1);
    tick();
    chk("s2_ld_stall_end", if1.stall, 0);
    chk("s2_ld_sc", if1.stall_cycles, 1);
    do_reset();
    prod(4'd3, 0, 1);
    tick();
    idle(); v = 1; wb = 1; dst = 4'd4; s2 = 4'd3; u2 = 1; #1;
    chk("s2_alu_nostall", if1.stall, 0);

    // hazard on R2 coincident with taken branch
    do_reset();
    prod(4'd2, 0, 1);
    tick();
    idle(); v = 1; wb = 1; dst = 4'd7; s1 = 4'd2; u1 = 1; br = 1; #1;
    chk("s3_stall", if0.stall, 0);
    chk("s3_flush", if0.flush, 1);
    chk("s3_bubble", if0.bubble, 1);
    tick();
    chk("s3_exe_v", u0.exe_q.v, 0);
    chk("s3_fc", if0.flush_count, 1);
    chk("s3_sc", if0.stall_cycles, 0);

    // unused source and non-writing producer
    do_reset();
    prod(4'd4, 0, 1);
    tick();
    idle(); v = 1; s1 = 4'd4; u1 = 0; s2 = 4'd0; u2 = 1; #1;
    chk("s4_unused_src", if0.stall, 0);
    tick();
    chk("s4_unused_src_mem", if0.stall, 0);
    do_reset();
    prod(4'd4, 0, 0);
    tick();
    idle(); v = 1; s1 = 4'd4; u1 = 1; #1;
    chk("s4_nowb_exe", if0.stall, 0);
    tick();
    chk("s4_nowb_mem", if0.stall, 0);

    // freeze during hazard on R5
    do_reset();
    prod(4'd5, 0, 1);
    tick();
    idle(); v = 1; wb = 1; dst = 4'd8; s1 = 4'd5; u1 = 1; fz = 1; #1;
    chk("s5_stall_fz", if0.stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_stall_hold", if0.stall, 1);
      chk("s5_exe_v_hold", u0.exe_q.v, 1);
      chk("s5_exe_dest_hold", u0.exe_q.dest, 5);
      chk("s5_sc_hold", if0.stall_cycles, 0);
    end
    fz = 0; #1;
    chk("s5_rel_stall1", if0.stall, 1);
    tick();
    chk("s5_rel_stall2", if0.stall, 1);
    tick();
    chk("s5_rel_clear", if0.stall, 0);
    chk("s5_rel_sc", if0.stall_cycles, 2);

    // saturation on 3-bit counters, then reset mid-stall
    do_reset();
    prod(4'd6, 0, 1);
    tick();
    idle(); v = 1; wb = 1; dst = 4'd6; s1 = 4'd6; u1 = 1; #1;
    for (int i = 0; i < 15; i++) tick();
    chk("s6_sat", if2.stall_cycles, 7);
    chk("s6_wide", if0.stall_cycles, 10);
    for (int i = 0; i < 3; i++) tick();
    chk("s6_sat_hold", if2.stall_cycles, 7);
    chk("s6_wide2", if0.stall_cycles, 12);
    chk("s6_pre_rst_stall", if2.stall, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("s6_rst_sc", if2.stall_cycles, 0);
    chk("s6_rst_fc", if2.flush_count, 0);
    chk("s6_rst_stall", if2.stall, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
